network_output_schedule: RTL and testbench

//   Selects the next buffer descriptor (bufid) for one network output port from QUEUE_NUM per-priority

---
 rtl/network_output_schedule_if.sv | 32 +++
 rtl/network_output_schedule.sv | 131 +++++++++++++
 tb/tb_network_output_schedule.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/network_output_schedule_if.sv
// Bundles the queue-side, gate-side and output-port signals of the output scheduler.
// Latency: none; wiring only.
// Backpressure: carried by i_outport_free (port side) and the per-queue empty flags (queue side).
interface network_output_schedule_if #(
  parameter int QUEUE_NUM   = 8,
  parameter int BUFID_WIDTH = 13
);
  logic [QUEUE_NUM-1:0]             iv_queue_empty;
  logic [QUEUE_NUM*BUFID_WIDTH-1:0] iv_queue_descriptor;
  logic [QUEUE_NUM-1:0]             ov_queue_rd;
  logic [QUEUE_NUM-1:0]             iv_gate_state;
  logic                             i_outport_free;
  logic [BUFID_WIDTH-1:0]           ov_descriptor;
  logic                             o_descriptor_wr;
  logic [1:0]                       ov_nos_state;
  logic [15:0]                      ov_debug_desc_cnt;
  logic [15:0]                      ov_debug_gated_cnt;

  // Queue FIFOs, gate list and output port side.
  modport master (
    output iv_queue_empty, iv_queue_descriptor, iv_gate_state, i_outport_free,
    input  ov_queue_rd, ov_descriptor, o_descriptor_wr, ov_nos_state,
    input  ov_debug_desc_cnt, ov_debug_gated_cnt
  );

  // Scheduler side.
  modport slave (
    input  iv_queue_empty, iv_queue_descriptor, iv_gate_state, i_outport_free,
    output ov_queue_rd, ov_descriptor, o_descriptor_wr, ov_nos_state,
    output ov_debug_desc_cnt, ov_debug_gated_cnt
  );
endinterface

// File: rtl/network_output_schedule.sv
// Picks the next buffer descriptor for one output port: strict priority outside RR_MASK, round-robin inside.
// Latency: FIFO read strobe in the ARB_S entry cycle; descriptor and write pulse registered 2 cycles later.
// Backpressure: waits in IDLE_S until i_outport_free; holds ARB_S while no queue is eligible.
module network_output_schedule #(
  parameter int                   QUEUE_NUM   = 8,
  parameter int                   BUFID_WIDTH = 13,
  parameter logic [QUEUE_NUM-1:0] RR_MASK     = 8'h1F
) (
  input logic                      i_clk,
  input logic                      i_rst,
  network_output_schedule_if.slave nos_bus
);

  localparam int QW = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;

  localparam logic [1:0] IDLE_S = 2'd0;
  localparam logic [1:0] ARB_S  = 2'd1;
  localparam logic [1:0] GET_S  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [QW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [QW-1:0]          sel_q, sel_d;
  logic                   init_flag_q, init_flag_d;
  logic [BUFID_WIDTH-1:0] desc_q, desc_d;
  logic                   desc_wr_q, desc_wr_d;
  logic [15:0]            desc_cnt_q, desc_cnt_d;
  logic [15:0]            gated_cnt_q, gated_cnt_d;

  logic [QUEUE_NUM-1:0]   eligible;
  logic [QUEUE_NUM-1:0]   strict_vec;
  logic [QUEUE_NUM-1:0]   rr_vec;
  logic [QW-1:0]          strict_idx;
  logic [QW-1:0]          rr_idx;
  logic [QW-1:0]          rr_cand;
  logic                   rr_hit;
  logic [QUEUE_NUM-1:0]   rd_vec;

  // Arbitration: highest eligible strict queue, else first eligible RR queue at or after rr_ptr.
  always_comb begin
    eligible   = ~nos_bus.iv_queue_empty & nos_bus.iv_gate_state;
    strict_vec = eligible & ~RR_MASK;
    rr_vec     = eligible & RR_MASK;
    strict_idx = '0;
    for (int i = 0; i < QUEUE_NUM; i++) begin
      if (strict_vec[i]) strict_idx = QW'(i);
    end
    rr_hit  = 1'b0;
    rr_idx  = '0;
    rr_cand = '0;
    for (int k = 0; k < QUEUE_NUM; k++) begin
      rr_cand = QW'((int'(rr_ptr_q) + k) % QUEUE_NUM);
      if (!rr_hit && rr_vec[rr_cand]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  // Next-state logic; the read strobe is combinational so it lines up with the grant cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    init_flag_d = init_flag_q;
    desc_d      = '0;
    desc_wr_d   = 1'b0;
    desc_cnt_d  = desc_cnt_q;
    gated_cnt_d = gated_cnt_q;
    rd_vec      = '0;
    case (state_q)
      IDLE_S: begin
        init_flag_d = 1'b0;
        if (nos_bus.i_outport_free || init_flag_q) state_d = ARB_S;
      end
      ARB_S: begin
        if (|strict_vec) begin
          rd_vec[strict_idx] = 1'b1;
          sel_d              = strict_idx;
          state_d            = GET_S;
        end else if (rr_hit) begin
          rd_vec[rr_idx] = 1'b1;
          sel_d          = rr_idx;
          rr_ptr_d       = QW'((int'(rr_idx) + 1) % QUEUE_NUM);
          state_d        = GET_S;
        end else if (|(~nos_bus.iv_queue_empty)) begin
          // Data is waiting but every non-empty queue has its gate closed.
          gated_cnt_d = gated_cnt_q + 16'd1;
        end
      end
      GET_S: begin
        // FIFO read data for the granted queue is valid one cycle after the strobe.
        desc_d     = nos_bus.iv_queue_descriptor[int'(sel_q)*BUFID_WIDTH +: BUFID_WIDTH];
        desc_wr_d  = 1'b1;
        desc_cnt_d = desc_cnt_q + 16'd1;
        state_d    = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  // State and output registers; reset abandons any read or grant in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE_S;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      init_flag_q <= 1'b1;
      desc_q      <= '0;
      desc_wr_q   <= 1'b0;
      desc_cnt_q  <= '0;
      gated_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      init_flag_q <= init_flag_d;
      desc_q      <= desc_d;
      desc_wr_q   <= desc_wr_d;
      desc_cnt_q  <= desc_cnt_d;
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign nos_bus.ov_queue_rd        = rd_vec;
  assign nos_bus.ov_descriptor      = desc_q;
  assign nos_bus.o_descriptor_wr    = desc_wr_q;
  assign nos_bus.ov_nos_state       = state_q;
  assign nos_bus.ov_debug_desc_cnt  = desc_cnt_q;
  assign nos_bus.ov_debug_gated_cnt = gated_cnt_q;

endmodule

// File: tb/tb_network_output_schedule.sv
// Directed bench for network_output_schedule with a small FIFO model per queue.
// FIFO model pops on the clock edge after a read strobe, so data is valid in GET_S.
// Inputs change at posedge+3; outputs are sampled at negedge+1.
module tb_network_output_schedule;

  logic clk;
  logic rst;

  network_output_schedule_if #(.QUEUE_NUM(8), .BUFID_WIDTH(13)) bus ();

  network_output_schedule #(
    .QUEUE_NUM  (8),
    .BUFID_WIDTH(13),
    .RR_MASK    (8'h1F)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .nos_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model storage: mem/npush written by stimulus, dat/npop by the model process.
  logic [12:0] mem [8][8];
  int          npush [8] = '{default: 0};
  int          npop  [8] = '{default: 0};
  logic [12:0] dat   [8] = '{default: 13'h0};

  int          glog [$];
  logic [12:0] dlog [$];
  int          wlog [$];
  int          cyc = 0;
  int          onehot_err = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always_comb begin
    bus.iv_queue_empty      = '0;
    bus.iv_queue_descriptor = '0;
    for (int q = 0; q < 8; q++) begin
      bus.iv_queue_empty[q]              = (npush[q] == npop[q]);
      bus.iv_queue_descriptor[q*13 +: 13] = dat[q];
    end
  end

  initial begin : fifo_model
    logic [7:0] rd_s;
    forever begin
      @(negedge clk);
      rd_s = bus.ov_queue_rd;
      if (rd_s != 8'h00) begin
        if (!$onehot(rd_s)) onehot_err++;
        for (int q = 0; q < 8; q++) if (rd_s[q]) glog.push_back(q);
      end
      if (bus.o_descriptor_wr) begin
        dlog.push_back(bus.ov_descriptor);
        wlog.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int q = 0; q < 8; q++) begin
        if (rd_s[q] && (npush[q] != npop[q])) begin
          dat[q] = mem[q][npop[q] % 8];
          npop[q]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int q, input logic [12:0] v);
    mem[q][npush[q] % 8] = v;
    npush[q]++;
  endtask

  task automatic wait_desc(input string tag, input int base, input int n, input int budget);
    int b;
    b = budget;
    while ((dlog.size() < base + n) && (b > 0)) begin
      at_neg();
      b--;
    end
    check(tag, dlog.size() - base, n);
  endtask

  initial begin
    int gb, db, b;
    int exp_q [6];
    logic [12:0] exp_d [6];
    exp_q = '{0, 1, 3, 0, 1, 3};
    exp_d = '{13'h100, 13'h110, 13'h130, 13'h101, 13'h111, 13'h131};

    rst                = 1'b1;
    bus.iv_gate_state  = 8'hFF;
    bus.i_outport_free = 1'b0;
    push(7, 13'h0A5);

    // Reset state
    at_neg();
    check("rst_state", bus.ov_nos_state, 2'd0);
    check("rst_rd", bus.ov_queue_rd, 8'h00);
    check("rst_desc", bus.ov_descriptor, 13'h0);
    check("rst_wr", bus.o_descriptor_wr, 1'b0);
    check("rst_desc_cnt", bus.ov_debug_desc_cnt, 16'h0);
    check("rst_gated_cnt", bus.ov_debug_gated_cnt, 16'h0);

    // 1: single strict queue, init_flag starts the first pass without outport_free
    tick();
    rst = 1'b0;
    at_neg();
    check("t1_idle", bus.ov_nos_state, 2'd0);
    at_neg();
    check("t1_arb", bus.ov_nos_state, 2'd1);
    check("t1_rd7", bus.ov_queue_rd, 8'h80);
    at_neg();
    check("t1_get", bus.ov_nos_state, 2'd2);
    check("t1_rd_off", bus.ov_queue_rd, 8'h00);
    check("t1_wr_early", bus.o_descriptor_wr, 1'b0);
    at_neg();
    check("t1_wr", bus.o_descriptor_wr, 1'b1);
    check("t1_desc", bus.ov_descriptor, 13'h0A5);
    check("t1_desc_cnt", bus.ov_debug_desc_cnt, 16'd1);
    at_neg();
    check("t1_wr_pulse", bus.o_descriptor_wr, 1'b0);
    check("t1_desc_clr", bus.ov_descriptor, 13'h0);
    check("t1_hold_idle", bus.ov_nos_state, 2'd0);

    // 2: strict queue 7 beats RR queue 2
    tick();
    gb = glog.size();
    db = dlog.size();
    push(7, 13'h077);
    push(2, 13'h022);
    bus.i_outport_free = 1'b1;
    wait_desc("t2_count", db, 2, 40);
    check("t2_grant0", glog[gb], 7);
    check("t2_grant1", glog[gb+1], 2);
    check("t2_desc0", dlog[db], 13'h077);
    check("t2_desc1", dlog[db+1], 13'h022);
    check("t2_desc_cnt", bus.ov_debug_desc_cnt, 16'd3);
    check("t2_gated_cnt", bus.ov_debug_gated_cnt, 16'd0);

    // 3: round-robin over queues 0,1,3 from a fresh rr_ptr
    tick();
    rst = 1'b1;
    tick();
    gb = glog.size();
    db = dlog.size();
    push(0, 13'h100); push(0, 13'h101);
    push(1, 13'h110); push(1, 13'h111);
    push(3, 13'h130); push(3, 13'h131);
    rst = 1'b0;
    wait_desc("t3_count", db, 6, 60);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_grant%0d", i), glog[gb+i], exp_q[i]);
      check($sformatf("t3_desc%0d", i), dlog[db+i], exp_d[i]);
    end
    check("t3_spacing", wlog[db+1] - wlog[db], 3);

    // 4: closed gate holds ARB_S and counts, opening it grants at once
    tick();
    gb = glog.size();
    db = dlog.size();
    bus.iv_gate_state = 8'hBF;
    push(6, 13'h066);
    at_neg();
    check("t4_arb", bus.ov_nos_state, 2'd1);
    check("t4_gated0", bus.ov_debug_gated_cnt, 16'd0);
    repeat (4) at_neg();
    check("t4_gated4", bus.ov_debug_gated_cnt, 16'd4);
    check("t4_no_rd", bus.ov_queue_rd, 8'h00);
    check("t4_still_arb", bus.ov_nos_state, 2'd1);
    tick();
    bus.iv_gate_state = 8'hFF;
    at_neg();
    check("t4_rd6", bus.ov_queue_rd, 8'h40);
    check("t4_gated5", bus.ov_debug_gated_cnt, 16'd5);
    wait_desc("t4_count", db, 1, 10);
    check("t4_desc", dlog[db], 13'h066);

    // 5: reset during GET_S, then init_flag issues one descriptor without outport_free
    tick();
    push(5, 13'h055);
    b = 10;
    while ((bus.ov_nos_state != 2'd2) && (b > 0)) begin
      at_neg();
      b--;
    end
    check("t5_reach_get", bus.ov_nos_state, 2'd2);
    #1;
    rst = 1'b1;
    #1;
    check("t5_state", bus.ov_nos_state, 2'd0);
    check("t5_wr", bus.o_descriptor_wr, 1'b0);
    check("t5_rd", bus.ov_queue_rd, 8'h00);
    check("t5_desc", bus.ov_descriptor, 13'h0);
    check("t5_desc_cnt", bus.ov_debug_desc_cnt, 16'd0);
    tick();
    bus.i_outport_free = 1'b0;
    db = dlog.size();
    push(4, 13'h044);
    tick();
    rst = 1'b0;
    wait_desc("t5_count", db, 1, 20);
    check("t5_init_desc", dlog[db], 13'h044);
    check("t5_desc_cnt1", bus.ov_debug_desc_cnt, 16'd1);
    tick();
    db = dlog.size();
    push(7, 13'h0EE);
    repeat (8) at_neg();
    check("t5_no_free_no_desc", dlog.size() - db, 0);
    check("t5_no_free_idle", bus.ov_nos_state, 2'd0);

    // 6: descriptor counter wraps from 16'hFFFF to 0
    at_neg();
    force dut.desc_cnt_q = 16'hFFFF;
    at_neg();
    release dut.desc_cnt_q;
    check("t6_preload", bus.ov_debug_desc_cnt, 16'hFFFF);
    tick();
    bus.i_outport_free = 1'b1;
    wait_desc("t6_count", db, 1, 20);
    check("t6_desc", dlog[db], 13'h0EE);
    check("t6_wrap", bus.ov_debug_desc_cnt, 16'h0000);

    check("rd_onehot", onehot_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
